// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, cycle counts,
// state encoding, commit modes and the combinational arithmetic helpers.
// Optional multiply-accumulate decode is enabled by the MD_MADD_EN macro in md_unit.
package md_pkg;

  // Operation codes presented on op when start=1
  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;

  // Busy lengths loaded into the down-counter on acceptance
  localparam logic [3:0] MULT_CYCLES = 4'd5;
  localparam logic [3:0] DIV_CYCLES  = 4'd10;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // What happens to {hi,lo} when the counter expires
  typedef enum logic [1:0] {
    CM_NONE  = 2'd0,  // leave hi/lo untouched (divide by zero)
    CM_WRITE = 2'd1,  // {hi,lo} = pending
    CM_ACC   = 2'd2   // {hi,lo} = {hi,lo} + pending
  } commit_t;

  // 64-bit product, operands sign- or zero-extended; result is modulo 2^64.
  function automatic logic [63:0] md_mul(input logic [31:0] x,
                                         input logic [31:0] y,
                                         input logic        is_signed);
    logic [63:0] ext_x;
    logic [63:0] ext_y;
    ext_x = {{32{is_signed & x[31]}}, x};
    ext_y = {{32{is_signed & y[31]}}, y};
    return ext_x * ext_y;
  endfunction

  // Returns {remainder, quotient}. Works on magnitudes so that the
  // 0x80000000 / -1 corner lands naturally on quotient 0x80000000, rem 0.
  // Quotient truncates toward zero; remainder takes the dividend's sign.
  function automatic logic [63:0] md_div(input logic [31:0] n,
                                         input logic [31:0] d,
                                         input logic        is_signed);
    logic        n_neg;
    logic        d_neg;
    logic [31:0] n_mag;
    logic [31:0] d_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] q;
    logic [31:0] r;
    n_neg = is_signed & n[31];
    d_neg = is_signed & d[31];
    n_mag = n_neg ? (~n + 32'd1) : n;
    d_mag = d_neg ? (~d + 32'd1) : d;
    // Zero divisor is never committed; substitute 1 to keep the datapath defined.
    if (d_mag == 32'd0) d_mag = 32'd1;
    q_mag = n_mag / d_mag;
    r_mag = n_mag % d_mag;
    q = (n_neg ^ d_neg) ? (~q_mag + 32'd1) : q_mag;
    r = n_neg ? (~r_mag + 32'd1) : r_mag;
    return {r, q};
  endfunction

endpackage

// File: rtl/md_unit.sv
// HI/LO multiply-divide unit: MULT/MULTU/DIV/DIVU/MTHI/MTLO (+MADD/MADDU when MD_MADD_EN is defined).
// Latency: mul/madd 5 cycles busy, div 10 cycles busy, MTHI/MTLO commit at the accepting edge.
// Backpressure: none on the port; starts while busy are dropped, so upstream stalls on (start | busy).
// Ports: clk; reset (async, active-low); start/op/a/b request from EX; busy; hi/lo architectural registers.
module md_unit
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic [63:0] r_pend;
  commit_t     r_mode;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_idle;
  logic        w_is_mul;
  logic        w_is_madd;
  logic        w_is_div;
  logic        w_signed;
  logic        w_div_zero;
  logic        w_last;
  logic [63:0] w_mul_res;
  logic [63:0] w_div_res;
  logic [63:0] w_acc_res;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
  assign w_is_div = (op == OP_DIV)  || (op == OP_DIVU);
`ifdef MD_MADD_EN
  assign w_is_madd = (op == OP_MADD) || (op == OP_MADDU);
`else
  assign w_is_madd = 1'b0;
`endif
  assign w_signed   = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD);
  assign w_div_zero = (b == 32'd0);

  // Operands are consumed here, at the accepting edge; the pending register
  // holds the result so later a/b changes cannot leak into it.
  assign w_mul_res = md_mul(a, b, w_signed);
  assign w_div_res = md_div(a, b, w_signed);

  // Accumulation uses hi/lo as they stand at completion.
  assign w_acc_res = {r_hi, r_lo} + r_pend;

  // Counter is 1 on the final busy cycle; it reaches 0 at the commit edge.
  assign w_last = (r_state == ST_RUN) && (r_cnt == 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_pend  <= 64'd0;
      r_mode  <= CM_NONE;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else if (w_idle) begin
      if (start) begin
        if (w_is_mul || w_is_madd) begin
          r_state <= ST_RUN;
          r_cnt   <= MULT_CYCLES;
          r_pend  <= w_mul_res;
          r_mode  <= w_is_madd ? CM_ACC : CM_WRITE;
        end else if (w_is_div) begin
          // Divide by zero still occupies the full busy window but commits nothing.
          r_state <= ST_RUN;
          r_cnt   <= DIV_CYCLES;
          r_pend  <= w_div_zero ? 64'd0 : w_div_res;
          r_mode  <= w_div_zero ? CM_NONE : CM_WRITE;
        end else if (op == OP_MTHI) begin
          r_hi <= a;
        end else if (op == OP_MTLO) begin
          r_lo <= a;
        end
      end
    end else begin
      r_cnt <= r_cnt - 4'd1;
      if (w_last) begin
        r_state <= ST_IDLE;
        case (r_mode)
          CM_WRITE: begin
            r_hi <= r_pend[63:32];
            r_lo <= r_pend[31:0];
          end
          CM_ACC: begin
            r_hi <= w_acc_res[63:32];
            r_lo <= w_acc_res[31:0];
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a driver predicts each result with a
// plain-arithmetic model and queues it; a monitor compares when the unit
// completes (busy falls) or one cycle after a single-cycle op.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cycles;
    logic [31:0] hi;
    logic [31:0] lo;
    int          at_edge;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int          edge_n = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  int          run_cnt = 0;
  bit          prev_busy = 1'b0;

  always @(posedge clk) edge_n = edge_n + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference model: update m_hi/m_lo from the architectural rules.
  task automatic predict(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output exp_t e);
    int              si;
    int              sj;
    longint          sx;
    longint          sy;
    longint          p;
    longint unsigned ux;
    longint unsigned uy;
    longint unsigned up;
    si = x; sj = y; sx = si; sy = sj; ux = x; uy = y;
    e.cycles = 0;
    case (o)
      4'd0: begin p = sx * sy; {m_hi, m_lo} = p; e.cycles = 5; end
      4'd1: begin up = ux * uy; {m_hi, m_lo} = up; e.cycles = 5; end
      4'd2: begin
        if (y != 0) begin
          p = sx / sy; m_lo = p[31:0];
          p = sx % sy; m_hi = p[31:0];
        end
        e.cycles = 10;
      end
      4'd3: begin
        if (y != 0) begin
          up = ux / uy; m_lo = up[31:0];
          up = ux % uy; m_hi = up[31:0];
        end
        e.cycles = 10;
      end
      4'd4: m_hi = x;
      4'd5: m_lo = x;
`ifdef MD_MADD_EN
      4'd6: begin p = sx * sy; {m_hi, m_lo} = {m_hi, m_lo} + p; e.cycles = 5; end
      4'd7: begin up = ux * uy; {m_hi, m_lo} = {m_hi, m_lo} + up; e.cycles = 5; end
`endif
      default: e.cycles = 0;
    endcase
    e.hi = m_hi;
    e.lo = m_lo;
    e.name = $sformatf("op%0d a=%h b=%h", o, x, y);
  endtask

  task automatic drive(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    exp_t e;
    predict(o, x, y, e);
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    e.at_edge = edge_n + 1;
    sb.push_back(e);
    @(posedge clk); #1;
    // Scramble operands to confirm results depend only on the accepting edge.
    start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    if (sb.size() != 0) begin
      n_chk++; n_err++;
      $display("FAIL timeout waiting for %s: got %0d outstanding, expected 0", sb[0].name, sb.size());
      sb.delete();
    end
  endtask

  task automatic op_wait(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    drive(o, x, y);
    wait_idle();
  endtask

  // Monitor
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      run_cnt = 0;
      prev_busy = 1'b0;
    end else begin
      if (busy) begin
        run_cnt++;
      end else if (prev_busy) begin
        if (sb.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL spurious completion: got busy drop, expected none (hi=%h lo=%h)", hi, lo);
        end else begin
          e = sb.pop_front();
          chk({e.name, " busy cycles"}, 64'(run_cnt), 64'(e.cycles));
          chk({e.name, " hi"}, {32'd0, hi}, {32'd0, e.hi});
          chk({e.name, " lo"}, {32'd0, lo}, {32'd0, e.lo});
        end
        run_cnt = 0;
      end else if (sb.size() > 0 && sb[0].cycles == 0 && sb[0].at_edge <= edge_n) begin
        e = sb.pop_front();
        chk({e.name, " busy"}, {63'd0, busy}, 64'd0);
        chk({e.name, " hi"}, {32'd0, hi}, {32'd0, e.hi});
        chk({e.name, " lo"}, {32'd0, lo}, {32'd0, e.lo});
      end
      prev_busy = busy;
    end
  end

  initial begin
    logic [31:0] x;
    logic [31:0] y;
    logic [3:0]  o;
    reset = 1'b0; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    #2;
    chk("reset busy", {63'd0, busy}, 64'd0);
    chk("reset hi", {32'd0, hi}, 64'd0);
    chk("reset lo", {32'd0, lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;

    // Directed cases
    op_wait(4'd0, 32'hFFFFFFFE, 32'd3);
    op_wait(4'd1, 32'hFFFFFFFE, 32'd3);
    op_wait(4'd2, 32'hFFFFFFF9, 32'd2);
    op_wait(4'd3, 32'd7, 32'd2);
    op_wait(4'd4, 32'h11, 32'd0);
    op_wait(4'd5, 32'h22, 32'd0);
    op_wait(4'd2, 32'h12345678, 32'd0);
    op_wait(4'd2, 32'h80000000, 32'hFFFFFFFF);
    op_wait(4'd9, 32'hAAAA5555, 32'd1);

    // MTHI arriving mid-DIV must be dropped
    op_wait(4'd4, 32'h99, 32'd0);
    drive(4'd2, 32'd17, 32'd5);
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1; op = 4'd4; a = 32'hDEAD;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle();

    // Accumulate / no-op depending on build
    op_wait(4'd4, 32'd0, 32'd0);
    op_wait(4'd5, 32'hFFFFFFFF, 32'd0);
    op_wait(4'd7, 32'd1, 32'd1);
    op_wait(4'd6, 32'hFFFFFFFF, 32'd5);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      o = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0: y = 32'd0;
        1: y = $urandom_range(1, 9);
        2: y = 32'hFFFFFFFF;
        default: y = $urandom;
      endcase
      x = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      op_wait(o, x, y);
    end

    // Reset in the third busy cycle of a MULT
    op_wait(4'd4, 32'h1234, 32'd0);
    op_wait(4'd5, 32'h5678, 32'd0);
    @(posedge clk); #1;
    start = 1'b1; op = 4'd0; a = 32'h00010003; b = 32'h00020005;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("midrun reset busy", {63'd0, busy}, 64'd0);
    chk("midrun reset hi", {32'd0, hi}, 64'd0);
    chk("midrun reset lo", {32'd0, lo}, 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (8) @(negedge clk);
    chk("no late commit busy", {63'd0, busy}, 64'd0);
    chk("no late commit hi", {32'd0, hi}, 64'd0);
    chk("no late commit lo", {32'd0, lo}, 64'd0);
    op_wait(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
